// File: rtl/ctrl_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_fsm_if : instruction, reg_file, ALU and data-memory signals of ctrl_fsm
// Rev 1.0
// ----------------------------------------------------------------------------
interface ctrl_fsm_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [9:0]        instr;
  logic [DATA_W-1:0] ReadA;
  logic [DATA_W-1:0] ReadB;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        srcA;
  logic [2:0]        srcB;
  logic              RegWrite;
  logic [DATA_W-1:0] writeValue;
  logic              busy;
  logic              halted;
  logic              mem_err;

  modport master (
    input  instr_valid, instr, ReadA, ReadB, alu_result, mem_rvalid, mem_rdata,
    output instr_ready, alu_op, mem_req, mem_we, mem_addr, mem_wdata,
           srcA, srcB, RegWrite, writeValue, busy, halted, mem_err
  );

  modport slave (
    output instr_valid, instr, ReadA, ReadB, alu_result, mem_rvalid, mem_rdata,
    input  instr_ready, alu_op, mem_req, mem_we, mem_addr, mem_wdata,
           srcA, srcB, RegWrite, writeValue, busy, halted, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_fsm : multicycle fetch/decode/writeback controller upstream of reg_file.
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt and set the sticky ill_op flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module ctrl_fsm #(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  ctrl_fsm_if.master bus
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       ill_op
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_WB       = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1001;
  localparam logic [3:0] OP_ST   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [9:0]        instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] write_value_q, write_value_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_err_q, mem_err_d;
`ifdef ILLEGAL_TRAP_EN
  logic              ill_op_q, ill_op_d;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      write_value_q <= '0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      write_value_q <= write_value_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_err_q     <= mem_err_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ill_op_q <= 1'b0;
    else        ill_op_q <= ill_op_d;
  end
  assign ill_op = ill_op_q;
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    write_value_d = write_value_q;
    cnt_d         = cnt_q;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_err_d     = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    ill_op_d      = ill_op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d = bus.ReadA;
        opb_d = bus.ReadB;
        cnt_d = '0;
        if (!instr_q[9]) begin
          state_d = S_EXEC;
        end else begin
          case (instr_q[9:6])
            OP_LDI: begin
              write_value_d = {{(DATA_W-3){instr_q[2]}}, instr_q[2:0]};
              state_d       = S_WB;
            end
            OP_LD: begin
              mem_req_d = 1'b1;
              state_d   = S_MEM_WAIT;
            end
            OP_ST: begin
              mem_req_d = 1'b1;
              mem_we_d  = 1'b1;
              state_d   = S_IDLE;
            end
            OP_HALT: state_d = S_HALT;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              ill_op_d = 1'b1;
              state_d  = S_HALT;
`else
              state_d  = S_IDLE;
`endif
            end
          endcase
        end
      end
      S_EXEC: begin
        write_value_d = bus.alu_result;
        state_d       = S_WB;
      end
      S_MEM_WAIT: begin
        // Data arriving on the timeout cycle itself still completes the load.
        if (bus.mem_rvalid) begin
          write_value_d = bus.mem_rdata;
          state_d       = S_WB;
        end else if (cnt_q == TIMEOUT) begin
          mem_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.RegWrite    = (state_q == S_WB);
  assign bus.alu_op      = instr_q[8:6];
  assign bus.srcA        = instr_q[5:3];
  assign bus.srcB        = instr_q[2:0];
  assign bus.writeValue  = write_value_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = opb_q;
  assign bus.mem_wdata   = opa_q;
  assign bus.mem_err     = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ctrl_fsm : directed table, corner sequences and random checks of ctrl_fsm
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ctrl_fsm;
  localparam int TO = 15;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  ctrl_fsm_if #(.DATA_W(16)) bus ();
`ifdef ILLEGAL_TRAP_EN
  logic ill_op;
`endif

  ctrl_fsm #(.DATA_W(16), .MEM_TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
`ifdef ILLEGAL_TRAP_EN
    ,
    .ill_op(ill_op)
`endif
  );

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return ~a;
    endcase
  endfunction

  // downstream reg_file and external ALU
  logic [15:0] rf  [8];
  logic [15:0] pre [8];
  logic        do_pre;
  assign bus.ReadA      = rf[bus.srcA];
  assign bus.ReadB      = rf[bus.srcB];
  assign bus.alu_result = alu(bus.ReadA, bus.ReadB, bus.alu_op);
  always @(posedge CLK) begin
    if (do_pre) begin
      for (int i = 0; i < 8; i++) rf[i] <= pre[i];
    end else if (bus.RegWrite) begin
      rf[bus.srcA] <= bus.writeValue;
    end
  end

  typedef struct {
    int          wb_cyc;
    int          wb_cnt;
    logic [2:0]  wb_reg;
    logic [15:0] wb_val;
    int          mem_cyc;
    int          mem_cnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    int          ready_cyc;
    int          halt_cyc;
    int          busy_bad;
  } obs_t;

  typedef struct {
    logic [9:0]  ins;
    int          rdly;
    logic [15:0] rdata;
    int          wb_cyc;
    logic [2:0]  wreg;
    logic [15:0] wval;
    int          mem_cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          rdy;
    logic        err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic obs_t blank();
    obs_t o;
    o = '{wb_cyc: -1, wb_cnt: 0, wb_reg: 3'd0, wb_val: 16'd0, mem_cyc: -1, mem_cnt: 0,
          mem_we: 1'b0, mem_addr: 16'd0, mem_wdata: 16'd0, ready_cyc: -1, halt_cyc: -1,
          busy_bad: 0};
    return o;
  endfunction

  // Issue one instruction and record what the controller does, cycle 0 = accept.
  task automatic run(input logic [9:0] ins, input int rdly, input logic [15:0] rdata,
                     input bit hold, output obs_t o);
    int req_c;
    bit done;
    o     = blank();
    req_c = -1;
    done  = 1'b0;
    @(negedge CLK);
    bus.mem_rvalid  = 1'b0;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    check("ready_at_issue", int'(bus.instr_ready), 1);
    @(posedge CLK);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge CLK);
      bus.mem_rvalid = 1'b0;
      if (bus.RegWrite) begin
        o.wb_cnt++;
        if (o.wb_cyc < 0) begin
          o.wb_cyc = c;
          o.wb_reg = bus.srcA;
          o.wb_val = bus.writeValue;
        end
      end
      if (bus.mem_req) begin
        o.mem_cnt++;
        if (o.mem_cyc < 0) begin
          o.mem_cyc   = c;
          o.mem_we    = bus.mem_we;
          o.mem_addr  = bus.mem_addr;
          o.mem_wdata = bus.mem_wdata;
          if (!bus.mem_we) req_c = c;
        end
      end
      if (bus.busy != (!bus.instr_ready && !bus.halted)) o.busy_bad++;
      if (rdly >= 0 && req_c >= 0 && c == req_c + rdly) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
      end
      if (bus.instr_ready && o.ready_cyc < 0) begin o.ready_cyc = c; done = 1'b1; end
      if (bus.halted && o.halt_cyc < 0)       begin o.halt_cyc  = c; done = 1'b1; end
    end
  endtask

  task automatic cmp(input string t, input obs_t o, input obs_t e);
    check({t, ".wb_cyc"}, o.wb_cyc, e.wb_cyc);
    check({t, ".wb_cnt"}, o.wb_cnt, e.wb_cnt);
    if (e.wb_cnt != 0) begin
      check({t, ".wb_reg"}, int'(o.wb_reg), int'(e.wb_reg));
      check({t, ".wb_val"}, int'(o.wb_val), int'(e.wb_val));
    end
    check({t, ".mem_cyc"}, o.mem_cyc, e.mem_cyc);
    check({t, ".mem_cnt"}, o.mem_cnt, e.mem_cnt);
    if (e.mem_cnt != 0) begin
      check({t, ".mem_we"},    int'(o.mem_we),    int'(e.mem_we));
      check({t, ".mem_addr"},  int'(o.mem_addr),  int'(e.mem_addr));
      check({t, ".mem_wdata"}, int'(o.mem_wdata), int'(e.mem_wdata));
    end
    check({t, ".ready_cyc"}, o.ready_cyc, e.ready_cyc);
    check({t, ".halt_cyc"},  o.halt_cyc,  e.halt_cyc);
    check({t, ".busy"},      o.busy_bad,  0);
  endtask

  // Transaction-level reference: effects and latencies per instruction class.
  logic [15:0] sh [8];
  int          sh_err;

  task automatic model(input logic [9:0] ins, input int rdly, input logic [15:0] rdata,
                       output obs_t e);
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    logic [15:0] a, b;
    e  = blank();
    op = ins[9:6];
    rd = ins[5:3];
    rs = ins[2:0];
    a  = sh[rd];
    b  = sh[rs];
    if (op < 4'd8) begin
      e.wb_cyc = 3; e.wb_val = alu(a, b, op[2:0]); e.ready_cyc = 4;
    end else if (op == 4'd8) begin
      e.wb_cyc = 2; e.wb_val = {{13{ins[2]}}, ins[2:0]}; e.ready_cyc = 3;
    end else if (op == 4'd9 || op == 4'd10) begin
      e.mem_cyc = 2; e.mem_cnt = 1; e.mem_we = (op == 4'd10);
      e.mem_addr = b; e.mem_wdata = a;
      if (op == 4'd10) begin
        e.ready_cyc = 2;
      end else if (rdly >= 0 && rdly <= TO) begin
        e.wb_cyc = 3 + rdly; e.wb_val = rdata; e.ready_cyc = 4 + rdly;
      end else begin
        e.ready_cyc = 3 + TO; sh_err = 1;
      end
    end else if (op == 4'd15) begin
      e.halt_cyc = 2;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      e.halt_cyc = 2;
`else
      e.ready_cyc = 2;
`endif
    end
    if (e.wb_cyc >= 0) begin
      e.wb_cnt = 1; e.wb_reg = rd; sh[rd] = e.wb_val;
    end
  endtask

  task automatic reset_mid(input string t, input logic [9:0] ins, input int at);
    int bad;
    @(negedge CLK);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge CLK);
    #1 bus.instr_valid = 1'b0;
    repeat (at) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check({t, ".ready"},   int'(bus.instr_ready), 1);
    check({t, ".busy"},    int'(bus.busy), 0);
    check({t, ".mem_err"}, int'(bus.mem_err), 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    @(negedge CLK);
    RST_N = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.RegWrite || bus.mem_req || !bus.instr_ready) bad++;
    end
    bus.mem_rvalid = 1'b0;
    check({t, ".quiet"}, bad, 0);
  endtask

  vec_t tbl [12];
  obs_t o, e;
  int   bad;

  initial begin
    // r0..r7 preload; expected columns follow the register contents row by row
    tbl[0]  = '{10'b0000_001_010, -1, 16'h0000,  3, 3'd1, 16'h0008, -1, 1'b0, 16'h0000, 16'h0000,  4, 1'b0};
    tbl[1]  = '{10'b1000_011_111, -1, 16'h0000,  2, 3'd3, 16'hFFFF, -1, 1'b0, 16'h0000, 16'h0000,  3, 1'b0};
    tbl[2]  = '{10'b1000_101_011, -1, 16'h0000,  2, 3'd5, 16'h0003, -1, 1'b0, 16'h0000, 16'h0000,  3, 1'b0};
    tbl[3]  = '{10'b1010_010_001, -1, 16'h0000, -1, 3'd0, 16'h0000,  2, 1'b1, 16'h0008, 16'h0003,  2, 1'b0};
    tbl[4]  = '{10'b1001_100_001,  4, 16'h1234,  7, 3'd4, 16'h1234,  2, 1'b0, 16'h0008, 16'h0000,  8, 1'b0};
    tbl[5]  = '{10'b0001_100_010, -1, 16'h0000,  3, 3'd4, 16'h1231, -1, 1'b0, 16'h0000, 16'h0000,  4, 1'b0};
    tbl[6]  = '{10'b1001_000_011, 15, 16'hABCD, 18, 3'd0, 16'hABCD,  2, 1'b0, 16'hFFFF, 16'h0010, 19, 1'b0};
    tbl[7]  = '{10'b1001_110_000, -1, 16'h0000, -1, 3'd0, 16'h0000,  2, 1'b0, 16'hABCD, 16'h1111, 18, 1'b1};
    tbl[8]  = '{10'b0100_111_001, -1, 16'h0000,  3, 3'd7, 16'h8008, -1, 1'b0, 16'h0000, 16'h0000,  4, 1'b1};
    tbl[9]  = '{10'b0010_000_101, -1, 16'h0000,  3, 3'd0, 16'h0001, -1, 1'b0, 16'h0000, 16'h0000,  4, 1'b1};
    tbl[10] = '{10'b1001_001_111,  0, 16'h5A5A,  3, 3'd1, 16'h5A5A,  2, 1'b0, 16'h8008, 16'h0008,  4, 1'b1};
    tbl[11] = '{10'b1001_010_000, 16, 16'h7777, -1, 3'd0, 16'h0000,  2, 1'b0, 16'h0001, 16'h0003, 18, 1'b1};

    RST_N           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    pre[0] = 16'h0010; pre[1] = 16'h0005; pre[2] = 16'h0003; pre[3] = 16'h0100;
    pre[4] = 16'h0000; pre[5] = 16'h00F0; pre[6] = 16'h1111; pre[7] = 16'h8000;
    do_pre = 1'b1;
    @(posedge CLK);
    #1 do_pre = 1'b0;
    check("rst.instr_ready", int'(bus.instr_ready), 1);
    check("rst.RegWrite",    int'(bus.RegWrite), 0);
    check("rst.mem_req",     int'(bus.mem_req), 0);
    check("rst.busy",        int'(bus.busy), 0);
    check("rst.halted",      int'(bus.halted), 0);
    check("rst.mem_err",     int'(bus.mem_err), 0);
    check("rst.writeValue",  int'(bus.writeValue), 0);
    check("rst.srcA",        int'(bus.srcA), 0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      e = blank();
      e.wb_cyc    = tbl[i].wb_cyc;
      e.wb_cnt    = (tbl[i].wb_cyc >= 0) ? 1 : 0;
      e.wb_reg    = tbl[i].wreg;
      e.wb_val    = tbl[i].wval;
      e.mem_cyc   = tbl[i].mem_cyc;
      e.mem_cnt   = (tbl[i].mem_cyc >= 0) ? 1 : 0;
      e.mem_we    = tbl[i].we;
      e.mem_addr  = tbl[i].addr;
      e.mem_wdata = tbl[i].wdata;
      e.ready_cyc = tbl[i].rdy;
      run(tbl[i].ins, tbl[i].rdly, tbl[i].rdata, 1'b0, o);
      cmp($sformatf("tbl%0d", i), o, e);
      check($sformatf("tbl%0d.mem_err", i), int'(bus.mem_err), int'(tbl[i].err));
    end

    // illegal opcode
    e = blank();
`ifdef ILLEGAL_TRAP_EN
    e.halt_cyc = 2;
`else
    e.ready_cyc = 2;
`endif
    run(10'b1100_000_000, -1, 16'h0, 1'b0, o);
    cmp("illegal", o, e);
`ifdef ILLEGAL_TRAP_EN
    check("illegal.ill_op", int'(ill_op), 1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1 check("illegal.ill_op_rst", int'(ill_op), 0);
    @(negedge CLK);
    RST_N = 1'b1;
`endif

    reset_mid("rst_ld",  10'b1001_001_010, 3);
    reset_mid("rst_alu", 10'b0000_011_011, 2);

    // HALT with instr_valid held high
    e = blank();
    e.halt_cyc = 2;
    run(10'b1111_000_000, -1, 16'h0, 1'b1, o);
    cmp("halt", o, e);
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.instr_ready || !bus.halted || bus.busy || bus.RegWrite) bad++;
    end
    check("halt.absorbing", bad, 0);
    RST_N           = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    check("halt.rst_ready",  int'(bus.instr_ready), 1);
    check("halt.rst_halted", int'(bus.halted), 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // randomized instructions against the reference model
    for (int i = 0; i < 8; i++) begin
      pre[i] = 16'($urandom);
      sh[i]  = pre[i];
    end
    sh_err = 0;
    @(negedge CLK);
    do_pre = 1'b1;
    @(negedge CLK);
    do_pre = 1'b0;
    for (int k = 0; k < 200; k++) begin
      int          kind;
      int          d;
      logic [9:0]  ins;
      logic [15:0] rdat;
      kind     = $urandom_range(0, 9);
      ins[5:0] = 6'($urandom);
      if (kind < 5)       ins[9:6] = {1'b0, 3'($urandom)};
      else if (kind < 7)  ins[9:6] = 4'b1000;
      else if (kind == 8) ins[9:6] = 4'b1010;
      else                ins[9:6] = 4'b1001;
      d = $urandom_range(0, 18);
      if (d >= 17) d = -1;
      rdat = 16'($urandom);
      model(ins, d, rdat, e);
      run(ins, d, rdat, 1'b0, o);
      cmp($sformatf("rnd%0d", k), o, e);
      check($sformatf("rnd%0d.mem_err", k), int'(bus.mem_err), sh_err);
    end
    @(negedge CLK);
    for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), int'(rf[i]), int'(sh[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
